small_module_arbiter: RTL and testbench

- Round-robin scheduler that time-shares one two-operand small_module datapath unit among N_REQ requesters.
- Each requester hands over an operand pair via valid/ready.
- The block drives the shared unit's in1/in2, waits UNIT_LAT cycles, captures out1 and returns it to the granted requester via a per-requester rsp_valid/rsp_ready handshake.
- Sits between the CPU-side operand producers and the single shared small_module instance.

---
 rtl/small_module_arbiter.sv | 139 +++++++++++++
 tb/tb_small_module_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/small_module_arbiter.sv
// rtl/small_module_arbiter.sv - time-shares one two-operand small_module unit among N_REQ requesters
// Round-robin by default; define SMALL_MODULE_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module small_module_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N_REQ    = 4,
    parameter int UNIT_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_in1,
    input  logic [N_REQ*WIDTH-1:0]   req_in2,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [WIDTH-1:0]         unit_in1,
    output logic [WIDTH-1:0]         unit_in2,
    input  logic [WIDTH-1:0]         unit_out1,
    output logic                     busy
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (UNIT_LAT > 0) ? $clog2(UNIT_LAT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [GW-1:0]    r_gnt, w_win;
    logic             w_found;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_unit_in1, r_unit_in2, r_rsp_data;
    logic [WIDTH-1:0] w_op1, w_op2;
    logic [N_REQ-1:0] r_rsp_valid;
    logic             w_accept, w_capture, w_rsp_done;

`ifdef SMALL_MODULE_ARB_FIXED_PRIO_EN
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found = 1'b1;
                w_win   = GW'(i);
            end
        end
    end
`else
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] w_idx;

    // Scan starts just after the last served requester so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = GW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end
`endif

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == GW'(i)) begin
                w_op1 = req_in1[i*WIDTH +: WIDTH];
                w_op2 = req_in2[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_capture  = (r_state == S_EXEC) && (r_cnt == CW'(UNIT_LAT));
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_gnt];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req_ready = N_REQ'(1) << w_win;
                    w_next    = S_EXEC;
                end
            end
            S_EXEC:  if (w_capture)  w_next = S_RESP;
            S_RESP:  if (w_rsp_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_unit_in1  <= '0;
            r_unit_in2  <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
`ifndef SMALL_MODULE_ARB_FIXED_PRIO_EN
            r_ptr       <= GW'(N_REQ - 1);
`endif
        end else begin
            if (w_accept) begin
                r_unit_in1 <= w_op1;
                r_unit_in2 <= w_op2;
                r_gnt      <= w_win;
                r_cnt      <= '0;
            end
            if (r_state == S_EXEC) r_cnt <= r_cnt + CW'(1);
            if (w_capture) begin
                r_rsp_data  <= unit_out1;
                r_rsp_valid <= N_REQ'(1) << r_gnt;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= '0;
`ifndef SMALL_MODULE_ARB_FIXED_PRIO_EN
                r_ptr       <= r_gnt;
`endif
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign unit_in1  = r_unit_in1;
    assign unit_in2  = r_unit_in2;
endmodule

// File: tb/tb_small_module_arbiter.sv
// tb/tb_small_module_arbiter.sv - directed self-checking bench for small_module_arbiter
module tb_small_module_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;

    // dut0: UNIT_LAT=0, unit model out1 = in1 + in2
    logic [3:0]  rv0 = '0, ready0, rspv0, rspr0 = '0;
    logic [31:0] in1_0 = '0, in2_0 = '0;
    logic [7:0]  rspd0, ui1_0, ui2_0, uo0;
    logic        busy0;

    // dut2: UNIT_LAT=2, unit model 0xFF for EXEC cycles 0-1 then 0x5A
    logic [3:0]  rv2 = '0, ready2, rspv2, rspr2 = '0;
    logic [31:0] in1_2 = '0, in2_2 = '0;
    logic [7:0]  rspd2, ui1_2, ui2_2, uo2;
    logic        busy2;
    int          cnt2 = 0;

    always #5 clk = ~clk;

    assign uo0 = ui1_0 + ui2_0;
    assign uo2 = (cnt2 < 2) ? 8'hFF : 8'h5A;

    always @(posedge clk) begin
        if (rst || !busy2) cnt2 <= 0;
        else               cnt2 <= cnt2 + 1;
    end

    small_module_arbiter #(.WIDTH(8), .N_REQ(4), .UNIT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(ready0),
        .req_in1(in1_0), .req_in2(in2_0), .rsp_valid(rspv0), .rsp_ready(rspr0),
        .rsp_data(rspd0), .unit_in1(ui1_0), .unit_in2(ui2_0), .unit_out1(uo0),
        .busy(busy0)
    );

    small_module_arbiter #(.WIDTH(8), .N_REQ(4), .UNIT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(ready2),
        .req_in1(in1_2), .req_in2(in2_2), .rsp_valid(rspv2), .rsp_ready(rspr2),
        .rsp_data(rspd2), .unit_in1(ui1_2), .unit_in2(ui2_2), .unit_out1(uo2),
        .busy(busy2)
    );

`ifdef SMALL_MODULE_ARB_FIXED_PRIO_EN
    localparam int NG = 4;
    logic [3:0] exp_order [NG] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    localparam int NG = 6;
    logic [3:0] exp_order [NG] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rv0 = '0; rv2 = '0; rspr0 = '0; rspr2 = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ready0, rspv0, rspd0, ui1_0, ui2_0, busy0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: got ready=%b rsp_valid=%b rsp_data=%h in1=%h in2=%h busy=%b want all 0",
                     ready0, rspv0, rspd0, ui1_0, ui2_0, busy0);
        end
        checks++;
        if ({ready2, rspv2, rspd2, ui1_2, ui2_2, busy2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: got ready=%b rsp_valid=%b busy=%b want all 0", ready2, rspv2, busy2);
        end
    endtask

    task automatic test_single_op();
        rv0 = 4'b0100; in1_0[23:16] = 8'h12; in2_0[23:16] = 8'h34;
        #1;
        checks++;
        if (ready0 !== 4'b0100 || busy0 !== 1'b0) begin
            errors++; $display("FAIL t1_accept: got ready=%b busy=%b want 0100 0", ready0, busy0);
        end
        step();
        rv0 = '0;
        checks++;
        if (ui1_0 !== 8'h12 || ui2_0 !== 8'h34 || busy0 !== 1'b1 || rspv0 !== 4'b0000) begin
            errors++;
            $display("FAIL t1_exec: got in1=%h in2=%h busy=%b rsp_valid=%b want 12 34 1 0000", ui1_0, ui2_0, busy0, rspv0);
        end
        step();
        checks++;
        if (rspv0 !== 4'b0100 || rspd0 !== 8'h46 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL t1_resp: got rsp_valid=%b rsp_data=%h busy=%b want 0100 46 1", rspv0, rspd0, busy0);
        end
        rspr0 = 4'b0100;
        step();
        rspr0 = '0;
        checks++;
        if (busy0 !== 1'b0 || rspv0 !== 4'b0000 || ui1_0 !== 8'h12 || ui2_0 !== 8'h34) begin
            errors++;
            $display("FAIL t1_done: got busy=%b rsp_valid=%b in1=%h in2=%h want 0 0000 12 34", busy0, rspv0, ui1_0, ui2_0);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        rspr0 = 4'b1111;
        rv0   = 4'b1111;
        #1;
        for (int g = 0; g < NG; g++) begin
            int w;
            w = 0;
            while (ready0 == 4'b0000 && w < 10) begin
                step();
                w++;
            end
            checks++;
            if (ready0 !== exp_order[g]) begin
                errors++;
                $display("FAIL t2_grant%0d: got ready=%b want %b", g, ready0, exp_order[g]);
            end
            step();
        end
        rv0 = '0;
        step(); step(); step();
        rspr0 = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rv0 = 4'b0001; in1_0[7:0] = 8'h05; in2_0[7:0] = 8'h06;
        #1;
        checks++;
        if (ready0 !== 4'b0001) begin
            errors++; $display("FAIL t3_accept0: got ready=%b want 0001", ready0);
        end
        step();
        rv0 = 4'b0010; in1_0[15:8] = 8'h21; in2_0[15:8] = 8'h10;
        #1;
        checks++;
        if (ready0 !== 4'b0000) begin
            errors++; $display("FAIL t3_exec_ready: got ready=%b want 0000", ready0);
        end
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rspv0 !== 4'b0001 || rspd0 !== 8'h0B || ready0 !== 4'b0000) begin
                errors++;
                $display("FAIL t3_hold%0d: got rsp_valid=%b rsp_data=%h ready=%b want 0001 0b 0000", k, rspv0, rspd0, ready0);
            end
            step();
        end
        rspr0 = 4'b0001;
        #1;
        checks++;
        if (ready0 !== 4'b0000) begin
            errors++; $display("FAIL t3_hs_ready: got ready=%b want 0000", ready0);
        end
        step();
        rspr0 = '0;
        checks++;
        if (ready0 !== 4'b0010 || busy0 !== 1'b0 || rspv0 !== 4'b0000) begin
            errors++;
            $display("FAIL t3_next_accept: got ready=%b busy=%b rsp_valid=%b want 0010 0 0000", ready0, busy0, rspv0);
        end
        step();
        rv0 = '0;
        checks++;
        if (ui1_0 !== 8'h21 || ui2_0 !== 8'h10 || busy0 !== 1'b1) begin
            errors++; $display("FAIL t3_req1_exec: got in1=%h in2=%h busy=%b want 21 10 1", ui1_0, ui2_0, busy0);
        end
        step();
        checks++;
        if (rspv0 !== 4'b0010 || rspd0 !== 8'h31) begin
            errors++; $display("FAIL t3_req1_resp: got rsp_valid=%b rsp_data=%h want 0010 31", rspv0, rspd0);
        end
    endtask

    task automatic test_foreign_rsp_ready();
        rspr0 = 4'b1000;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (rspv0 !== 4'b0010 || rspd0 !== 8'h31 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL t6_foreign: got rsp_valid=%b rsp_data=%h busy=%b want 0010 31 1", rspv0, rspd0, busy0);
        end
        rspr0 = 4'b0010;
        step();
        rspr0 = '0;
        checks++;
        if (rspv0 !== 4'b0000 || busy0 !== 1'b0) begin
            errors++; $display("FAIL t6_release: got rsp_valid=%b busy=%b want 0000 0", rspv0, busy0);
        end
    endtask

    task automatic test_latency2();
        rv2 = 4'b0001; in1_2[7:0] = 8'h01; in2_2[7:0] = 8'h02;
        #1;
        checks++;
        if (ready2 !== 4'b0001) begin
            errors++; $display("FAIL t4_accept: got ready=%b want 0001", ready2);
        end
        step();
        rv2 = '0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (rspv2 !== 4'b0000 || busy2 !== 1'b1) begin
                errors++; $display("FAIL t4_exec%0d: got rsp_valid=%b busy=%b want 0000 1", k, rspv2, busy2);
            end
            step();
        end
        checks++;
        if (rspv2 !== 4'b0001 || rspd2 !== 8'h5A) begin
            errors++; $display("FAIL t4_resp: got rsp_valid=%b rsp_data=%h want 0001 5a", rspv2, rspd2);
        end
        rspr2 = 4'b0001;
        step();
        rspr2 = '0;
        checks++;
        if (busy2 !== 1'b0 || rspv2 !== 4'b0000) begin
            errors++; $display("FAIL t4_done: got busy=%b rsp_valid=%b want 0 0000", busy2, rspv2);
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        rv0 = 4'b1000; in1_0[31:24] = 8'h40; in2_0[31:24] = 8'h02;
        rspr0 = 4'b1111;
        step();
        rv0 = '0;
        rst = 1'b1;
        step();
        checks++;
        if ({ready0, rspv0, rspd0, ui1_0, ui2_0, busy0} !== '0) begin
            errors++;
            $display("FAIL t5_reset: got ready=%b rsp_valid=%b rsp_data=%h in1=%h in2=%h busy=%b want all 0",
                     ready0, rspv0, rspd0, ui1_0, ui2_0, busy0);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rspv0 !== 4'b0000 || busy0 !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL t5_dropped: got stray rsp_valid/busy=%b want 0", seen);
        end
        rv0 = 4'b1001; in1_0[7:0] = 8'h07; in2_0[7:0] = 8'h08;
        #1;
        checks++;
        if (ready0 !== 4'b0001) begin
            errors++; $display("FAIL t5_prio: got ready=%b want 0001", ready0);
        end
        step();
        rv0 = '0;
        step();
        checks++;
        if (rspv0 !== 4'b0001 || rspd0 !== 8'h0F) begin
            errors++; $display("FAIL t5_resp: got rsp_valid=%b rsp_data=%h want 0001 0f", rspv0, rspd0);
        end
        step();
        rspr0 = '0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_foreign_rsp_ready();
        test_latency2();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
